// File: rtl/excep_sequencer.sv
// excep_sequencer
// Sequences a precise exception. It accepts a request from the ID stage,
// flushes ID, EX and MEM one stage per cycle, redirects fetch to the handler
// and tracks the handler until eret. A second exception raised while the
// handler runs is a double fault, which halts the core until reset.
//
// Ports
//   clk, rst      : clock; synchronous active-high reset
//   excep_req     : exception request (level, held until id_flush is seen)
//   excep_pc      : PC of the faulting ID instruction
//   excep_opcode  : opcode of the faulting instruction
//   pipe_stall    : pipeline hold; blocks acceptance and eret
//   eret          : return-from-exception decoded in ID
//   id/ex/mem_flush, pc_redirect, redirect_pc : pipeline control
//   epc, cause    : captured exception PC and opcode
//   in_handler    : handler executing
//   halt          : double-fault halt
//   excep_count   : accepted exceptions, saturating
//   state_dbg     : current FSM state, for observation only
//
// Handshake: excep_req is a level request, and acceptance is its handshake.
// A request is taken on a clock edge where the FSM is idle, excep_req=1 and
// pipe_stall=0. The source sees id_flush on the following cycle and may then
// drop the request. eret is taken only in HANDLER with pipe_stall=0.
module excep_sequencer #(
    parameter logic [31:0] HANDLER_ADDR = 32'h0000_0100,
    parameter int          CNT_W        = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             excep_req,
    input  logic [31:0]      excep_pc,
    input  logic [6:0]       excep_opcode,
    input  logic             pipe_stall,
    input  logic             eret,
    output logic             id_flush,
    output logic             ex_flush,
    output logic             mem_flush,
    output logic             pc_redirect,
    output logic [31:0]      redirect_pc,
    output logic [31:0]      epc,
    output logic [6:0]       cause,
    output logic             in_handler,
    output logic             halt,
    output logic [CNT_W-1:0] excep_count,
    output logic [2:0]       state_dbg
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FLUSH_ID  = 3'd1,
        FLUSH_EX  = 3'd2,
        FLUSH_MEM = 3'd3,
        REDIRECT  = 3'd4,
        HANDLER   = 3'd5,
        RETURN    = 3'd6,
        FATAL     = 3'd7
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        epc_q, epc_d;
    logic [6:0]         cause_q, cause_d;
    logic [CNT_W-1:0]   count_q, count_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            epc_q   <= '0;
            cause_q <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            epc_q   <= epc_d;
            cause_q <= cause_d;
            count_q <= count_d;
        end
    end

    // Next-state logic. The flush and redirect states advance unconditionally.
    always_comb begin
        state_d = state_q;
        epc_d   = epc_q;
        cause_d = cause_q;
        count_d = count_q;
        case (state_q)
            IDLE: begin
                if (excep_req && !pipe_stall) begin
                    epc_d   = excep_pc;
                    cause_d = excep_opcode;
                    count_d = (count_q == '1) ? count_q : count_q + CNT_W'(1);
                    state_d = FLUSH_ID;
                end
            end
            FLUSH_ID:  state_d = FLUSH_EX;
            FLUSH_EX:  state_d = FLUSH_MEM;
            FLUSH_MEM: state_d = REDIRECT;
            REDIRECT:  state_d = HANDLER;
            HANDLER: begin
                // A fault inside the handler wins over a simultaneous eret.
                // epc/cause keep the original fault.
                if (excep_req)
                    state_d = FATAL;
                else if (eret && !pipe_stall)
                    state_d = RETURN;
            end
            RETURN:  state_d = IDLE;
            FATAL:   state_d = FATAL;
            default: state_d = IDLE;
        endcase
    end

    // Moore outputs, decoded from the state register only.
    always_comb begin
        id_flush    = 1'b0;
        ex_flush    = 1'b0;
        mem_flush   = 1'b0;
        pc_redirect = 1'b0;
        redirect_pc = 32'h0;
        in_handler  = 1'b0;
        halt        = 1'b0;
        case (state_q)
            FLUSH_ID:  id_flush = 1'b1;
            FLUSH_EX:  ex_flush = 1'b1;
            FLUSH_MEM: mem_flush = 1'b1;
            REDIRECT: begin
                pc_redirect = 1'b1;
                redirect_pc = HANDLER_ADDR;
            end
            HANDLER: in_handler = 1'b1;
            RETURN: begin
                pc_redirect = 1'b1;
                id_flush    = 1'b1;
                redirect_pc = epc_q + 32'd4;  // wraps modulo 2^32
            end
            FATAL: begin
                halt      = 1'b1;
                id_flush  = 1'b1;
                ex_flush  = 1'b1;
                mem_flush = 1'b1;
            end
            default: ;
        endcase
    end

    assign epc         = epc_q;
    assign cause       = cause_q;
    assign excep_count = count_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_excep_sequencer.sv
module tb_excep_sequencer;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, excep_req, pipe_stall, eret;
  logic [31:0] excep_pc;
  logic [6:0]  excep_opcode;

  logic        id_flush, ex_flush, mem_flush, pc_redirect, in_handler, halt;
  logic [31:0] redirect_pc, epc;
  logic [6:0]  cause;
  logic [7:0]  excep_count;
  logic [2:0]  state_dbg;

  logic        id_flush2, ex_flush2, mem_flush2, pc_redirect2, in_handler2, halt2;
  logic [31:0] redirect_pc2, epc2;
  logic [6:0]  cause2;
  logic [1:0]  excep_count2;
  logic [2:0]  state_dbg2;

  excep_sequencer dut (
    .clk(clk), .rst(rst), .excep_req(excep_req), .excep_pc(excep_pc),
    .excep_opcode(excep_opcode), .pipe_stall(pipe_stall), .eret(eret),
    .id_flush(id_flush), .ex_flush(ex_flush), .mem_flush(mem_flush),
    .pc_redirect(pc_redirect), .redirect_pc(redirect_pc), .epc(epc),
    .cause(cause), .in_handler(in_handler), .halt(halt),
    .excep_count(excep_count), .state_dbg(state_dbg)
  );

  excep_sequencer #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .excep_req(excep_req), .excep_pc(excep_pc),
    .excep_opcode(excep_opcode), .pipe_stall(pipe_stall), .eret(eret),
    .id_flush(id_flush2), .ex_flush(ex_flush2), .mem_flush(mem_flush2),
    .pc_redirect(pc_redirect2), .redirect_pc(redirect_pc2), .epc(epc2),
    .cause(cause2), .in_handler(in_handler2), .halt(halt2),
    .excep_count(excep_count2), .state_dbg(state_dbg2)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Tracks the position in the exception sequence as "cycles since
  // acceptance" (1..4), plus handler/return/fatal flags.
  int          m_seq;
  bit          m_handler, m_ret, m_fatal;
  logic [31:0] m_epc;
  logic [6:0]  m_cause;
  int          m_cnt8, m_cnt2;

  task automatic model_reset();
    m_seq = 0; m_handler = 0; m_ret = 0; m_fatal = 0;
    m_epc = 0; m_cause = 0; m_cnt8 = 0; m_cnt2 = 0;
  endtask

  // Called at each posedge with the inputs that edge samples.
  task automatic model_step();
    if (rst) model_reset();
    else if (m_fatal) ;
    else if (m_seq > 0) begin
      if (m_seq == 4) begin m_seq = 0; m_handler = 1; end
      else m_seq = m_seq + 1;
    end else if (m_ret) m_ret = 0;
    else if (m_handler) begin
      if (excep_req) begin m_fatal = 1; m_handler = 0; end
      else if (eret && !pipe_stall) begin m_ret = 1; m_handler = 0; end
    end else if (excep_req && !pipe_stall) begin
      m_epc = excep_pc; m_cause = excep_opcode; m_seq = 1;
      if (m_cnt8 < 255) m_cnt8++;
      if (m_cnt2 < 3) m_cnt2++;
    end
  endtask

  function automatic logic [63:0] exp_ctl();
    logic [31:0] rpc;
    rpc = (m_seq == 4) ? 32'h100 : (m_ret ? m_epc + 32'd4 : 32'h0);
    return {25'b0, (m_seq == 1) || m_ret || m_fatal, (m_seq == 2) || m_fatal,
            (m_seq == 3) || m_fatal, (m_seq == 4) || m_ret, m_handler, m_fatal, rpc};
  endfunction

  function automatic logic [63:0] act_ctl(input bit second);
    if (second)
      return {25'b0, id_flush2, ex_flush2, mem_flush2, pc_redirect2, in_handler2, halt2, redirect_pc2};
    return {25'b0, id_flush, ex_flush, mem_flush, pc_redirect, in_handler, halt, redirect_pc};
  endfunction

  task automatic check_model();
    chk("model_ctl", act_ctl(0), exp_ctl());
    chk("model_ctl_w2", act_ctl(1), exp_ctl());
    chk("model_epc_cause", {25'b0, cause, epc}, {25'b0, m_cause, m_epc});
    chk("model_cnt8", 64'(excep_count), 64'(m_cnt8));
    chk("model_cnt2", 64'(excep_count2), 64'(m_cnt2));
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic r, input logic q, input logic [31:0] pc,
                      input logic [6:0] op, input logic s, input logic e);
    rst = r; excep_req = q; excep_pc = pc; excep_opcode = op; pipe_stall = s; eret = e;
    @(posedge clk);
    model_step();
    #1;
    check_model();
  endtask

  task automatic idle_step();
    step(0, 0, 32'h0, 7'h0, 0, 0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        r, q;
    logic [31:0] pc;
    logic [6:0]  op;
    logic        s, e;
    logic [3:0]  fl;     // {id, ex, mem, redirect}
    logic [31:0] rpc;
    logic        ih, h;
    logic [31:0] epc;
    logic [6:0]  cause;
    logic [7:0]  cnt;
  } vec_t;

  vec_t tbl[20];

  initial begin
    rst = 1; excep_req = 0; excep_pc = 0; excep_opcode = 0; pipe_stall = 0; eret = 0;
    model_reset();

    //           r  q  pc            op     s  e  fl       rpc           ih h  epc           cause  cnt
    tbl[0]  = '{0, 1, 32'h40,       7'h7A, 0, 0, 4'b1000, 32'h0,       0, 0, 32'h40, 7'h7A, 8'd1};
    tbl[1]  = '{0, 0, 32'h0,        7'h0,  0, 0, 4'b0100, 32'h0,       0, 0, 32'h40, 7'h7A, 8'd1};
    tbl[2]  = '{0, 0, 32'h0,        7'h0,  0, 0, 4'b0010, 32'h0,       0, 0, 32'h40, 7'h7A, 8'd1};
    tbl[3]  = '{0, 0, 32'h0,        7'h0,  0, 0, 4'b0001, 32'h100,     0, 0, 32'h40, 7'h7A, 8'd1};
    tbl[4]  = '{0, 0, 32'h0,        7'h0,  0, 0, 4'b0000, 32'h0,       1, 0, 32'h40, 7'h7A, 8'd1};
    tbl[5]  = '{0, 0, 32'h0,        7'h0,  0, 1, 4'b1001, 32'h44,      0, 0, 32'h40, 7'h7A, 8'd1};
    tbl[6]  = '{0, 0, 32'h0,        7'h0,  0, 0, 4'b0000, 32'h0,       0, 0, 32'h40, 7'h7A, 8'd1};
    tbl[7]  = '{0, 0, 32'h0,        7'h0,  0, 1, 4'b0000, 32'h0,       0, 0, 32'h40, 7'h7A, 8'd1};
    tbl[8]  = '{0, 1, 32'h80,       7'h11, 1, 0, 4'b0000, 32'h0,       0, 0, 32'h40, 7'h7A, 8'd1};
    tbl[9]  = '{0, 1, 32'h80,       7'h11, 1, 0, 4'b0000, 32'h0,       0, 0, 32'h40, 7'h7A, 8'd1};
    tbl[10] = '{0, 1, 32'h80,       7'h11, 1, 0, 4'b0000, 32'h0,       0, 0, 32'h40, 7'h7A, 8'd1};
    tbl[11] = '{0, 1, 32'h80,       7'h11, 0, 0, 4'b1000, 32'h0,       0, 0, 32'h80, 7'h11, 8'd2};
    tbl[12] = '{0, 1, 32'h90,       7'h22, 1, 1, 4'b0100, 32'h0,       0, 0, 32'h80, 7'h11, 8'd2};
    tbl[13] = '{0, 0, 32'h0,        7'h0,  0, 0, 4'b0010, 32'h0,       0, 0, 32'h80, 7'h11, 8'd2};
    tbl[14] = '{0, 0, 32'h0,        7'h0,  0, 0, 4'b0001, 32'h100,     0, 0, 32'h80, 7'h11, 8'd2};
    tbl[15] = '{0, 0, 32'h0,        7'h0,  0, 0, 4'b0000, 32'h0,       1, 0, 32'h80, 7'h11, 8'd2};
    tbl[16] = '{0, 1, 32'hDEAD,     7'h33, 0, 0, 4'b1110, 32'h0,       0, 1, 32'h80, 7'h11, 8'd2};
    tbl[17] = '{0, 0, 32'h0,        7'h0,  0, 0, 4'b1110, 32'h0,       0, 1, 32'h80, 7'h11, 8'd2};
    tbl[18] = '{0, 1, 32'hBEEF,     7'h44, 0, 1, 4'b1110, 32'h0,       0, 1, 32'h80, 7'h11, 8'd2};
    tbl[19] = '{1, 1, 32'h55,       7'h55, 0, 1, 4'b0000, 32'h0,       0, 0, 32'h0,  7'h0,  8'd0};

    // reset state
    step(1, 0, 32'h0, 7'h0, 0, 0);
    step(1, 1, 32'h1234, 7'h12, 0, 1);
    chk("reset_outputs", {25'b0, id_flush, ex_flush, mem_flush, pc_redirect, in_handler, halt, redirect_pc}, 64'h0);
    chk("reset_epc_cause_cnt", {17'b0, cause, epc, excep_count}, 64'h0);

    // table
    for (int i = 0; i < 20; i++) begin
      step(tbl[i].r, tbl[i].q, tbl[i].pc, tbl[i].op, tbl[i].s, tbl[i].e);
      chk($sformatf("tbl%0d_flush_redir", i), {60'b0, id_flush, ex_flush, mem_flush, pc_redirect}, 64'(tbl[i].fl));
      chk($sformatf("tbl%0d_rpc_ih_halt", i), {30'b0, in_handler, halt, redirect_pc}, {30'b0, tbl[i].ih, tbl[i].h, tbl[i].rpc});
      chk($sformatf("tbl%0d_epc_cause_cnt", i), {17'b0, cause, epc, excep_count}, {17'b0, tbl[i].cause, tbl[i].epc, tbl[i].cnt});
    end

    // rst during FLUSH_EX
    step(0, 1, 32'h300, 7'h0C, 0, 0);
    idle_step();
    chk("in_flush_ex", 64'(ex_flush), 64'd1);
    step(1, 1, 32'h0, 7'h0, 0, 0);
    chk("rst_mid_flush", {23'b0, id_flush, ex_flush, mem_flush, pc_redirect, in_handler, halt, cause, epc, excep_count},
        64'h0);

    // handler: stalled eret holds, eret+req together goes FATAL
    step(0, 1, 32'h500, 7'h0D, 0, 0);
    for (int i = 0; i < 4; i++) idle_step();
    step(0, 0, 32'h0, 7'h0, 1, 1);
    chk("stalled_eret_holds", {62'b0, in_handler, pc_redirect}, 64'b10);
    step(0, 1, 32'h600, 7'h0E, 0, 1);
    chk("req_beats_eret", {60'b0, halt, id_flush, ex_flush, mem_flush}, 64'hF);
    chk("fatal_epc_kept", 64'(epc), 64'h500);
    step(1, 0, 32'h0, 7'h0, 0, 0);

    // four full rounds: 2-bit counter saturates, epc+4 wraps
    for (int r = 0; r < 4; r++) begin
      step(0, 1, (r == 3) ? 32'hFFFF_FFFC : 32'h200 + 32'(r * 16), 7'h01, 0, 0);
      for (int i = 0; i < 4; i++) idle_step();
      step(0, 0, 32'h0, 7'h0, 0, 1);
      if (r == 3) chk("wrap_rpc", {31'b0, pc_redirect, redirect_pc}, {31'b0, 1'b1, 32'h0});
      idle_step();
      if (r >= 2) chk($sformatf("cnt2_round%0d", r), 64'(excep_count2), 64'd3);
    end

    // randomized run against the model
    step(1, 0, 32'h0, 7'h0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 39) == 0, $urandom_range(0, 3) == 0, $urandom,
           7'($urandom), $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/excep_sequencer.md
EXCEP_SEQUENCER -- requirements
Module: excep_sequencer

Interface
REQ-001 Parameter HANDLER_ADDR, default 32'h0000_0100, exception handler entry PC.
REQ-002 Parameter CNT_W, default 8, exception counter width.
REQ-003 clk  input  1  clock; all state updates on posedge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 excep_req  input  1  exception request from ID-stage detection; level, held by source until id_flush seen.
REQ-006 excep_pc  input  32  PC of faulting ID instruction.
REQ-007 excep_opcode  input  7  opcode of faulting instruction.
REQ-008 pipe_stall  input  1  pipeline hold; blocks exception acceptance and eret.
REQ-009 eret  input  1  return-from-exception decoded in ID.
REQ-010 id_flush  output  1  flush ID stage.
REQ-011 ex_flush  output  1  flush EX stage.
REQ-012 mem_flush  output  1  flush MEM stage.
REQ-013 pc_redirect  output  1  PC mux select override.
REQ-014 redirect_pc  output  32  redirect target.
REQ-015 epc  output  32  captured exception PC.
REQ-016 cause  output  7  captured opcode.
REQ-017 in_handler  output  1  handler executing.
REQ-018 halt  output  1  double-fault halt.
REQ-019 excep_count  output  CNT_W  accepted exceptions, saturating.

Function
REQ-020 States SHALL be IDLE, FLUSH_ID, FLUSH_EX, FLUSH_MEM, REDIRECT, HANDLER, RETURN, FATAL; all outputs registered/Moore from state.
REQ-021 IDLE: excep_req=1 and pipe_stall=0 at edge N SHALL capture epc<=excep_pc, cause<=excep_opcode, excep_count+1, next FLUSH_ID; id_flush high in cycle N+1.
REQ-022 IDLE with pipe_stall=1 SHALL stay IDLE, no capture, regardless of excep_req.
REQ-023 FLUSH_ID (id_flush=1), FLUSH_EX (ex_flush=1), FLUSH_MEM (mem_flush=1) SHALL each last exactly one cycle, in that order, ignoring pipe_stall, excep_req, eret.
REQ-024 REDIRECT SHALL assert pc_redirect=1, redirect_pc=HANDLER_ADDR for one cycle, then HANDLER.
REQ-025 HANDLER SHALL assert in_handler=1; eret=1 and pipe_stall=0 -> RETURN; excep_req=1 -> FATAL; both same cycle -> FATAL (excep_req wins).
REQ-026 RETURN SHALL assert pc_redirect=1, id_flush=1, redirect_pc=epc+4 (32-bit, 32'hFFFF_FFFC wraps to 0), one cycle, then IDLE.
REQ-027 FATAL SHALL assert halt=1 and all three flush outputs=1 continuously; exit only by rst.
REQ-028 eret in IDLE SHALL be ignored.
REQ-029 excep_count SHALL saturate at all-ones, never wrap.
REQ-030 epc and cause SHALL hold from capture until next accepted exception or reset; not overwritten on double fault.
REQ-031 redirect_pc SHALL be 0 whenever pc_redirect=0.
REQ-032 Minimum exception-to-handler latency 4 cycles (accept edge to REDIRECT cycle).

Reset
REQ-033 rst=1 at posedge SHALL force IDLE, all outputs 0, epc=0, cause=0, excep_count=0, from any state including mid-flush and FATAL.
REQ-034 rst SHALL dominate every other input in the same cycle.

Verification
REQ-035 excep_req=1, excep_pc=32'h40, opcode=7'h7A, no stall -> id/ex/mem_flush on consecutive cycles, then pc_redirect with 32'h100, epc=32'h40, cause=7'h7A, count=1.
REQ-036 In HANDLER, eret=1 -> one cycle pc_redirect=1, id_flush=1, redirect_pc=32'h44, then IDLE, in_handler=0.
REQ-037 excep_req=1 with pipe_stall=1 for 3 cycles -> no flush, no capture; stall drop -> sequence starts next cycle.
REQ-038 excep_req=1 during HANDLER -> halt=1 and all flushes=1 persistently, epc unchanged; rst -> all zero.
REQ-039 rst asserted in FLUSH_EX -> next cycle IDLE, all outputs 0, count=0.
REQ-040 CNT_W=2, four full exception/eret rounds -> excep_count=3 after third and fourth; epc=32'hFFFF_FFFC eret -> redirect_pc=0.
